// File: rtl/ebpc_pkg.sv
// Shared definitions for the EBPC stream datapath.
// DATA_W       : compressed-stream word width
// unpk_state_t : stream_unpacker block state (EMPTY / RUN / DRAIN)
package ebpc_pkg;

    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } unpk_state_t;

endpackage

// File: rtl/stream_unpacker_if.sv
// Handshake bundle around stream_unpacker.
// Word side   : data_i, last_i, vld_i in; rdy_o out (unpacker view)
// Window side : data_o, fill_o, vld_o out; len_i, rdy_i in (unpacker view)
// Modports    : slave = the unpacker, master = its environment (FIFO + symbol decoder)
interface stream_unpacker_if #(
    parameter int unsigned DATA_W = ebpc_pkg::DATA_W
) ();

    localparam int unsigned LEN_W  = $clog2(DATA_W + 1);
    localparam int unsigned FILL_W = $clog2(2 * DATA_W + 1);

    logic [DATA_W-1:0] data_i;
    logic              last_i;
    logic              vld_i;
    logic              rdy_o;

    logic [DATA_W-1:0] data_o;
    logic [FILL_W-1:0] fill_o;
    logic              vld_o;
    logic [LEN_W-1:0]  len_i;
    logic              rdy_i;

    modport slave (
        input  data_i, last_i, vld_i, len_i, rdy_i,
        output rdy_o, data_o, fill_o, vld_o
    );

    modport master (
        output data_i, last_i, vld_i, len_i, rdy_i,
        input  rdy_o, data_o, fill_o, vld_o
    );

endinterface

// File: rtl/stream_unpacker.sv
// Decoder-side bit unpacker: keeps stream bits left-aligned in a 2*DATA_W window and
// lets the symbol decoder consume 0..DATA_W bits per transfer.
// clk_i, rst_ni : clock, async active-low reset
// bus (slave)   : word input handshake and consumer window handshake
// discard_i     : drop everything buffered and return to EMPTY
// idle_o        : no block in progress
module stream_unpacker #(
    parameter int unsigned DATA_W = ebpc_pkg::DATA_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    stream_unpacker_if.slave bus,
    input  logic             discard_i,
    output logic             idle_o
);
    import ebpc_pkg::*;

    localparam int unsigned BUF_W  = 2 * DATA_W;
    localparam int unsigned LEN_W  = $clog2(DATA_W + 1);
    localparam int unsigned FILL_W = $clog2(BUF_W + 1);

    unpk_state_t       st_q, st_d;
    logic [BUF_W-1:0]  buf_q, buf_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [FILL_W-1:0] take;
    logic              accept;
    logic              vld_q, rdy_q, idle_q;
    logic [DATA_W-1:0] data_q;

    // Next window: consume from the top, then append the new word right below the remaining bits.
    always_comb begin
        take   = (vld_q && bus.rdy_i) ? FILL_W'(bus.len_i) : '0;
        accept = bus.vld_i && rdy_q && !discard_i;
        st_d   = st_q;

        // Over-consumption (only possible in DRAIN) saturates to an empty window.
        if (take > fill_q) begin
            buf_d  = '0;
            fill_d = '0;
        end else begin
            buf_d  = buf_q << take;
            fill_d = fill_q - take;
        end

        if (accept) begin
            buf_d  = buf_d | ({bus.data_i, DATA_W'(0)} >> fill_d);
            fill_d = fill_d + FILL_W'(DATA_W);
        end

        case (st_q)
            EMPTY:   if (accept) st_d = bus.last_i ? DRAIN : RUN;
            RUN:     if (accept && bus.last_i) st_d = DRAIN;
            DRAIN:   if (fill_d == '0) st_d = EMPTY;
            default: st_d = EMPTY;
        endcase

        if (discard_i) begin
            buf_d  = '0;
            fill_d = '0;
            st_d   = EMPTY;
        end
    end

    // State, window and outputs; outputs are registered from the next-state values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_q   <= EMPTY;
            buf_q  <= '0;
            fill_q <= '0;
            vld_q  <= 1'b0;
            rdy_q  <= 1'b1;
            data_q <= '0;
            idle_q <= 1'b1;
        end else begin
            st_q   <= st_d;
            buf_q  <= buf_d;
            fill_q <= fill_d;
            vld_q  <= ((st_d == RUN) && (fill_d >= FILL_W'(DATA_W))) ||
                      ((st_d == DRAIN) && (fill_d != '0));
            rdy_q  <= (st_d != DRAIN) && (fill_d <= FILL_W'(DATA_W));
            data_q <= buf_d[BUF_W-1 -: DATA_W];
            idle_q <= (st_d == EMPTY);
        end
    end

    assign bus.vld_o  = vld_q;
    assign bus.rdy_o  = rdy_q;
    assign bus.data_o = data_q;
    assign bus.fill_o = fill_q;
    assign idle_o     = idle_q;

    a_tail_zero: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (buf_q << fill_q) == '0);
    a_len_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (vld_q && bus.rdy_i) |-> (bus.len_i <= LEN_W'(DATA_W)));
    a_drain_len: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (vld_q && bus.rdy_i && (st_q == DRAIN)) |-> (FILL_W'(bus.len_i) <= fill_q));
    a_fill_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        fill_q <= FILL_W'(BUF_W));

endmodule

// File: tb/tb_stream_unpacker.sv
// Self-checking bench for stream_unpacker (DATA_W=8): directed cases, then random traffic,
// compared against a bit-queue model of the stream.
module tb_stream_unpacker;

    localparam int DW = 8;

    logic clk_i = 1'b0;
    logic rst_ni;
    logic discard_i;
    logic idle_o;

    stream_unpacker_if #(.DATA_W(DW)) bus ();

    stream_unpacker #(.DATA_W(DW)) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .bus       (bus),
        .discard_i (discard_i),
        .idle_o    (idle_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: buffered stream bits in order, plus block status.
    bit mq[$];
    bit m_block;
    bit m_drain;

    int n_tests;
    int n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit m_vld();
        return (m_block && !m_drain && mq.size() >= DW) || (m_drain && mq.size() > 0);
    endfunction

    function automatic bit m_rdy();
        return !m_drain && mq.size() <= DW;
    endfunction

    task automatic check_all(input string tag);
        logic [DW-1:0] ed;
        ed = '0;
        for (int i = 0; i < DW; i++)
            if (i < mq.size()) ed[DW-1-i] = mq[i];
        check({tag, ".data"}, 32'(bus.data_o), 32'(ed));
        check({tag, ".fill"}, 32'(bus.fill_o), 32'(mq.size()));
        check({tag, ".vld"},  32'(bus.vld_o),  32'(m_vld()));
        check({tag, ".rdy"},  32'(bus.rdy_o),  32'(m_rdy()));
        check({tag, ".idle"}, 32'(idle_o),     32'(!m_block));
    endtask

    // Drive one cycle of inputs, advance the model, then compare at the following negedge.
    task automatic cycle(input logic [DW-1:0] d, input logic last, input logic vi,
                         input logic [3:0] len, input logic ri, input logic disc,
                         input string tag);
        bit mv, mr;
        mv = m_vld();
        mr = m_rdy();
        bus.data_i = d;
        bus.last_i = last;
        bus.vld_i  = vi;
        bus.len_i  = len;
        bus.rdy_i  = ri;
        discard_i  = disc;
        if (disc) begin
            mq.delete();
            m_block = 1'b0;
            m_drain = 1'b0;
        end else begin
            if (mv && ri) repeat (int'(len)) void'(mq.pop_front());
            if (vi && mr) begin
                for (int i = DW - 1; i >= 0; i--) mq.push_back(d[i]);
                m_block = 1'b1;
                if (last) m_drain = 1'b1;
            end
            if (m_drain && mq.size() == 0) begin
                m_drain = 1'b0;
                m_block = 1'b0;
            end
        end
        @(posedge clk_i);
        @(negedge clk_i);
        check_all(tag);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".vld"},  32'(bus.vld_o),  32'd0);
        check({tag, ".rdy"},  32'(bus.rdy_o),  32'd1);
        check({tag, ".idle"}, 32'(idle_o),     32'd1);
        check({tag, ".data"}, 32'(bus.data_o), 32'h00);
        check({tag, ".fill"}, 32'(bus.fill_o), 32'd0);
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        m_block    = 1'b0;
        m_drain    = 1'b0;
        rst_ni     = 1'b0;
        bus.data_i = '0;
        bus.last_i = 1'b0;
        bus.vld_i  = 1'b0;
        bus.len_i  = '0;
        bus.rdy_i  = 1'b0;
        discard_i  = 1'b0;

        repeat (2) @(negedge clk_i);
        check_reset_values("reset");
        rst_ni = 1'b1;
        @(negedge clk_i);
        check_all("post_reset");

        // Two words, then a 3-bit consume.
        cycle(8'hA5, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, "push_a5");
        check("push_a5.data_k", 32'(bus.data_o), 32'hA5);
        cycle(8'h3C, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, "push_3c");
        check("push_3c.fill_k", 32'(bus.fill_o), 32'd16);
        check("push_3c.rdy_k",  32'(bus.rdy_o),  32'd0);
        cycle(8'h00, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, "take3");
        check("take3.data_k", 32'(bus.data_o), 32'h29);
        check("take3.fill_k", 32'(bus.fill_o), 32'd13);
        check("take3.rdy_k",  32'(bus.rdy_o),  32'd0);
        cycle(8'h00, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0, "take5");
        check("take5.data_k", 32'(bus.data_o), 32'h3C);

        // Full-throughput: consume 8 and push in the same cycle.
        cycle(8'h0F, 1'b0, 1'b1, 4'd8, 1'b1, 1'b0, "thru");
        check("thru.data_k", 32'(bus.data_o), 32'h0F);
        check("thru.fill_k", 32'(bus.fill_o), 32'd8);
        check("thru.vld_k",  32'(bus.vld_o),  32'd1);

        // Last word enters DRAIN, then drains to EMPTY.
        cycle(8'hC0, 1'b1, 1'b1, 4'd8, 1'b1, 1'b0, "last_c0");
        check("last_c0.rdy_k", 32'(bus.rdy_o), 32'd0);
        cycle(8'h00, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, "drain2");
        check("drain2.fill_k", 32'(bus.fill_o), 32'd6);
        check("drain2.vld_k",  32'(bus.vld_o),  32'd1);
        cycle(8'h00, 1'b0, 1'b0, 4'd6, 1'b1, 1'b0, "drain6");
        check("drain6.idle_k", 32'(idle_o),      32'd1);
        check("drain6.vld_k",  32'(bus.vld_o),   32'd0);

        // Discard in DRAIN with 5 bits left.
        cycle(8'hE7, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, "last_e7");
        cycle(8'h00, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, "drain3");
        check("drain3.fill_k", 32'(bus.fill_o), 32'd5);
        cycle(8'h55, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1, "disc_drain");
        check("disc_drain.fill_k", 32'(bus.fill_o), 32'd0);
        check("disc_drain.rdy_k",  32'(bus.rdy_o),  32'd1);

        // Discard in RUN while a word is offered: the word must not be taken.
        cycle(8'h11, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, "push_11");
        cycle(8'h22, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1, "disc_run");
        check("disc_run.fill_k", 32'(bus.fill_o), 32'd0);

        // Full window, consumer stalled.
        cycle(8'h12, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, "push_12");
        cycle(8'h34, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, "push_34");
        for (int k = 0; k < 10; k++) begin
            cycle(8'h99, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0, "stall");
            check("stall.data_k", 32'(bus.data_o), 32'h12);
        end

        // Asynchronous reset mid-block.
        #2 rst_ni = 1'b0;
        #1 check_reset_values("mid_reset");
        mq.delete();
        m_block = 1'b0;
        m_drain = 1'b0;
        bus.vld_i = 1'b0;
        bus.rdy_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check_all("after_reset");

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            int sz, lmax;
            logic [3:0] len;
            sz   = mq.size();
            lmax = (m_drain && sz < DW) ? sz : DW;
            len  = 4'($urandom_range(0, lmax));
            cycle(8'($urandom),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 9) < 7),
                  len,
                  ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 49) == 0),
                  "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
